// File: rtl/hyper_rx_deser.sv
// HyperBus read-data deserialiser: RWDS-toggle beats are packed into BEATS-beat words and buffered in a FWFT FIFO.
// Define HYPER_RX_TIMEOUT_EN to add the beat-timeout watchdog (timeout_o is tied low otherwise).
module hyper_rx_deser #(
   parameter int DQ_WIDTH       = 8,
   parameter int BEATS          = 2,
   parameter int FIFO_DEPTH     = 8,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                            clk0,
   input  logic                            rst_ni,
   input  logic                            enable_i,
   input  logic                            start_i,
   input  logic                            abort_i,
   input  logic [CNT_WIDTH-1:0]            burst_len_i,
   input  logic                            beat_toggle_i,
   input  logic [DQ_WIDTH-1:0]             ddr_pos_i,
   input  logic [DQ_WIDTH-1:0]             ddr_neg_i,
   output logic [2*DQ_WIDTH*BEATS-1:0]     data_o,
   output logic                            valid_o,
   input  logic                            ready_i,
   output logic [$clog2(FIFO_DEPTH):0]     level_o,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            overflow_o,
   output logic                            timeout_o
);
   localparam int LANE_W = 2*DQ_WIDTH;
   localparam int WORD_W = LANE_W*BEATS;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;
   state_t state, state_nxt;

   logic                 toggle_q;
   logic [IDX_W-1:0]     beat_idx;
   logic [WORD_W-1:0]    word_asm;
   logic [WORD_W-1:0]    word_full;
   logic [CNT_WIDTH-1:0] words_left;
   logic [WORD_W-1:0]    mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W:0]       count;
   logic                 beat, word_done, last_word, full, pop, push, drop;
   logic                 load, done_nxt, timeout_hit;

   // abort_i and a timeout both override a beat seen in the same cycle
   assign beat      = enable_i & (state == RECV) & (beat_toggle_i ^ toggle_q) & ~abort_i & ~timeout_hit;
   assign word_done = beat & (beat_idx == IDX_W'(BEATS-1));
   assign last_word = word_done & (words_left == CNT_WIDTH'(1));
   assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign pop       = (count != '0) & ready_i;
   assign push      = word_done & (~full | pop);
   assign drop      = word_done & full & ~pop;

   assign valid_o = (count != '0);
   assign level_o = count;
   assign busy_o  = (state != IDLE);
   assign data_o  = mem[rd_ptr];

   always_comb begin
      word_full = word_asm;
      word_full[beat_idx*LANE_W +: LANE_W] = {ddr_pos_i, ddr_neg_i};
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      done_nxt  = 1'b0;
      if (abort_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  if (burst_len_i != '0) begin
                     state_nxt = RECV;
                     load      = 1'b1;
                  end else begin
                     done_nxt = 1'b1;
                  end
               end
            end
            RECV: begin
               if (timeout_hit || last_word) state_nxt = DRAIN;
            end
            DRAIN: begin
               if ((count == '0) || ((count == (PTR_W+1)'(1)) && pop)) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk0 or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= IDLE;
         toggle_q   <= 1'b0;
         beat_idx   <= '0;
         word_asm   <= '0;
         words_left <= '0;
         done_o     <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         state    <= state_nxt;
         toggle_q <= beat_toggle_i;
         done_o   <= done_nxt;
         if (abort_i || load || timeout_hit) begin
            beat_idx <= '0;
         end else if (beat) begin
            beat_idx <= word_done ? '0 : beat_idx + 1'b1;
            word_asm <= word_full;
         end
         // dropped words still count, so the burst length stays exact
         if (load)           words_left <= burst_len_i;
         else if (word_done) words_left <= words_left - 1'b1;
         if (load)      overflow_o <= 1'b0;
         else if (drop) overflow_o <= 1'b1;
      end
   end

   always_ff @(posedge clk0 or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (abort_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= word_full;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

`ifdef HYPER_RX_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES+1);
   logic [IDLE_W-1:0] idle_cnt;

   assign timeout_hit = (state == RECV) && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES));

   always_ff @(posedge clk0 or negedge rst_ni) begin
      if (!rst_ni) begin
         idle_cnt  <= '0;
         timeout_o <= 1'b0;
      end else begin
         if ((state == RECV) && !beat && !timeout_hit) idle_cnt <= idle_cnt + 1'b1;
         else                                          idle_cnt <= '0;
         if (load)                         timeout_o <= 1'b0;
         else if (timeout_hit && !abort_i) timeout_o <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_hyper_rx_deser.sv
// Randomised and directed bench for hyper_rx_deser, scored against a queue-based transaction model.
module tb_hyper_rx_deser;
   localparam int BEATS = 2;
   localparam int DEPTH = 8;
   localparam int TMO   = 64;

   logic        clk0 = 1'b0;
   logic        rst_ni, enable_i, start_i, abort_i, beat_toggle_i, ready_i;
   logic [15:0] burst_len_i;
   logic [7:0]  ddr_pos_i, ddr_neg_i;
   logic [31:0] data_o;
   logic        valid_o, busy_o, done_o, overflow_o, timeout_o;
   logic [3:0]  level_o;

   int checks = 0;
   int errors = 0;

   // reference model: FIFO contents as a queue, burst progress as plain counters
   int          m_ph;
   logic [31:0] m_q[$];
   int          m_lanes, m_left, m_idle;
   logic [31:0] m_part;
   bit          m_ovf, m_tmo, m_done, m_tq;
   logic [31:0] popped[$];
   int          done_seen;

   always #5 clk0 = ~clk0;

   hyper_rx_deser dut (
      .clk0(clk0), .rst_ni(rst_ni), .enable_i(enable_i), .start_i(start_i), .abort_i(abort_i),
      .burst_len_i(burst_len_i), .beat_toggle_i(beat_toggle_i), .ddr_pos_i(ddr_pos_i), .ddr_neg_i(ddr_neg_i),
      .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .level_o(level_o), .busy_o(busy_o),
      .done_o(done_o), .overflow_o(overflow_o), .timeout_o(timeout_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void m_reset();
      m_ph = 0; m_q.delete(); m_lanes = 0; m_left = 0; m_idle = 0; m_part = '0;
      m_ovf = 0; m_tmo = 0; m_done = 0; m_tq = 0;
   endfunction

   function automatic void model_step();
      bit pop, beat, nd;
      nd   = 0;
      pop  = (m_q.size() != 0) && ready_i;
      beat = enable_i && (m_ph == 1) && (beat_toggle_i != m_tq);
      if (abort_i) begin
         m_q.delete(); m_lanes = 0; m_ph = 0;
      end else begin
         if (pop) void'(m_q.pop_front());
         case (m_ph)
            0: if (start_i) begin
                  if (burst_len_i == 0) nd = 1;
                  else begin
                     m_ph = 1; m_left = int'(burst_len_i); m_ovf = 0; m_tmo = 0; m_lanes = 0; m_idle = 0;
                  end
               end
            1: begin
`ifdef HYPER_RX_TIMEOUT_EN
               if (m_idle == TMO) begin
                  m_tmo = 1; m_lanes = 0; m_ph = 2;
               end else
`endif
               if (beat) begin
                  m_part[m_lanes*16 +: 16] = {ddr_pos_i, ddr_neg_i};
                  m_idle = 0;
                  m_lanes++;
                  if (m_lanes == BEATS) begin
                     m_lanes = 0;
                     if (m_q.size() < DEPTH) m_q.push_back(m_part);
                     else m_ovf = 1;
                     m_left--;
                     if (m_left == 0) m_ph = 2;
                  end
               end else begin
                  m_idle++;
               end
            end
            default: if (m_q.size() == 0) begin m_ph = 0; nd = 1; end
         endcase
      end
      m_done = nd;
      m_tq   = beat_toggle_i;
   endfunction

   task automatic compare();
      check("valid", 32'(valid_o), 32'(m_q.size() != 0));
      check("level", 32'(level_o), 32'(m_q.size()));
      check("busy", 32'(busy_o), 32'(m_ph != 0));
      check("done", 32'(done_o), 32'(m_done));
      check("overflow", 32'(overflow_o), 32'(m_ovf));
      check("timeout", 32'(timeout_o), 32'(m_tmo));
      if (m_q.size() != 0) check("data", data_o, m_q[0]);
   endtask

   task automatic cyc();
      if (valid_o && ready_i) popped.push_back(data_o);
      @(posedge clk0);
      model_step();
      #1;
      if (done_o) done_seen++;
      compare();
   endtask

   task automatic beat_in(input logic [7:0] p, input logic [7:0] n);
      ddr_pos_i = p; ddr_neg_i = n; beat_toggle_i = ~beat_toggle_i;
      cyc();
   endtask

   task automatic start_burst(input int len);
      burst_len_i = 16'(len); start_i = 1'b1;
      cyc();
      start_i = 1'b0;
   endtask

   task automatic drain_wait(input string tag);
      int n = 0;
      while (busy_o && n < 40) begin cyc(); n++; end
      check(tag, 32'(busy_o), 32'd0);
   endtask

   function automatic logic [31:0] got(input int i);
      return (popped.size() > i) ? popped[i] : 32'hDEAD_DEAD;
   endfunction

   function automatic logic [31:0] t2_word(input int w);
      return {8'(8'h10 + 2*w + 1), 8'(8'h80 + 2*w + 1), 8'(8'h10 + 2*w), 8'(8'h80 + 2*w)};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_ni = 1'b0; enable_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; burst_len_i = '0;
      beat_toggle_i = 1'b0; ddr_pos_i = '0; ddr_neg_i = '0; ready_i = 1'b0;
      m_reset();
      #12;
      compare();
      check("rst_data", data_o, 32'd0);
      @(negedge clk0);
      rst_ni = 1'b1;
      cyc();

      // basic two-word burst
      enable_i = 1'b1; ready_i = 1'b1; popped.delete(); done_seen = 0;
      start_burst(2);
      beat_in(8'hA1, 8'hB1); beat_in(8'hA2, 8'hB2); beat_in(8'hA3, 8'hB3); beat_in(8'hA4, 8'hB4);
      drain_wait("t1_drain");
      cyc(); cyc();
      check("t1_pops", 32'(popped.size()), 32'd2);
      check("t1_w0", got(0), 32'hA2B2_A1B1);
      check("t1_w1", got(1), 32'hA4B4_A3B3);
      check("t1_done_cnt", 32'(done_seen), 32'd1);

      // overflow: FIFO fills, last two words dropped
      ready_i = 1'b0;
      start_burst(10);
      for (int i = 0; i < 20; i++) beat_in(8'(8'h10 + i), 8'(8'h80 + i));
      check("t2_level", 32'(level_o), 32'd8);
      check("t2_ovf", 32'(overflow_o), 32'd1);
      check("t2_busy", 32'(busy_o), 32'd1);
      popped.delete(); done_seen = 0; ready_i = 1'b1;
      drain_wait("t2_drain");
      check("t2_pops", 32'(popped.size()), 32'd8);
      for (int w = 0; w < 8; w++) check($sformatf("t2_w%0d", w), got(w), t2_word(w));
      check("t2_done_cnt", 32'(done_seen), 32'd1);

      // toggles while disabled are not beats
      popped.delete();
      start_burst(1);
      enable_i = 1'b0;
      beat_in(8'hEE, 8'hEE); beat_in(8'hEE, 8'hEE); beat_in(8'hEE, 8'hEE);
      enable_i = 1'b1;
      cyc();
      beat_in(8'hC1, 8'hD1); beat_in(8'hC2, 8'hD2);
      drain_wait("t3_drain");
      check("t3_w0", got(0), 32'hC2D2_C1D1);

      // abort mid-burst
      ready_i = 1'b0; done_seen = 0;
      start_burst(3);
      beat_in(8'hE1, 8'hF1); beat_in(8'hE2, 8'hF2); beat_in(8'hE3, 8'hF3);
      abort_i = 1'b1;
      cyc();
      abort_i = 1'b0;
      check("t4_valid", 32'(valid_o), 32'd0);
      check("t4_busy", 32'(busy_o), 32'd0);
      cyc();
      check("t4_no_done", 32'(done_seen), 32'd0);
      popped.delete(); ready_i = 1'b1;
      start_burst(1);
      beat_in(8'h71, 8'h72); beat_in(8'h73, 8'h74);
      drain_wait("t4_drain");
      check("t4_w0", got(0), 32'h7374_7172);
      check("t4_done_cnt", 32'(done_seen), 32'd1);

      // zero-length burst and start ignored while receiving
      start_burst(0);
      check("t5_done", 32'(done_o), 32'd1);
      check("t5_busy", 32'(busy_o), 32'd0);
      cyc();
      check("t5_done_gone", 32'(done_o), 32'd0);
      popped.delete(); done_seen = 0;
      start_burst(2);
      beat_in(8'h11, 8'h22);
      start_i = 1'b1; burst_len_i = 16'd5;
      beat_in(8'h33, 8'h44);
      start_i = 1'b0;
      beat_in(8'h55, 8'h66); beat_in(8'h77, 8'h88);
      drain_wait("t5_drain");
      check("t5_pops", 32'(popped.size()), 32'd2);
      check("t5_w0", got(0), 32'h3344_1122);
      check("t5_w1", got(1), 32'h7788_5566);
      check("t5_done_cnt", 32'(done_seen), 32'd1);

      // beat timeout
      popped.delete(); done_seen = 0;
      start_burst(2);
      beat_in(8'h91, 8'h92); beat_in(8'h93, 8'h94); beat_in(8'h95, 8'h96);
      repeat (TMO + 6) cyc();
`ifdef HYPER_RX_TIMEOUT_EN
      check("t6_tmo", 32'(timeout_o), 32'd1);
      check("t6_busy", 32'(busy_o), 32'd0);
      check("t6_pops", 32'(popped.size()), 32'd1);
      check("t6_w0", got(0), 32'h9394_9192);
      check("t6_done_cnt", 32'(done_seen), 32'd1);
`else
      check("t6_tmo", 32'(timeout_o), 32'd0);
      check("t6_busy", 32'(busy_o), 32'd1);
      abort_i = 1'b1;
      cyc();
      abort_i = 1'b0;
`endif

      // async reset mid-burst
      start_burst(4);
      beat_in(8'h01, 8'h02); beat_in(8'h03, 8'h04); beat_in(8'h05, 8'h06);
      rst_ni = 1'b0;
      m_reset();
      #2;
      compare();
      check("t7_data", data_o, 32'd0);
      @(negedge clk0);
      rst_ni = 1'b1;
      cyc();

      // randomised traffic
      for (int c = 0; c < 1500; c++) begin
         enable_i    = ($urandom_range(0, 9) != 0);
         ready_i     = ($urandom_range(0, 9) < 7);
         start_i     = ($urandom_range(0, 9) == 0);
         burst_len_i = 16'($urandom_range(0, 12));
         abort_i     = ($urandom_range(0, 149) == 0);
         ddr_pos_i   = 8'($urandom);
         ddr_neg_i   = 8'($urandom);
         if ($urandom_range(0, 1) == 1) beat_toggle_i = ~beat_toggle_i;
         cyc();
      end
      start_i = 1'b0; abort_i = 1'b1;
      cyc();
      abort_i = 1'b0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
